// File: rtl/led_pkg.sv
// Shared encodings for the DE10 LED-pattern projects: sequencer modes and
// LED pattern styles.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_BOUNCE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  localparam int PAT_ONEHOT = 0;
  localparam int PAT_BAR    = 1;

endpackage

// File: rtl/led_pattern_decode.sv
// Combinational state-index to LED decoder: one-hot marker or bar graph.
// An index beyond the LED bank lights nothing (one-hot) or the full bar.
module led_pattern_decode
  import led_pkg::*;
#(
  parameter int STATE_W = 3,
  parameter int LED_W   = 10,
  parameter int PATTERN = PAT_ONEHOT
) (
  input  logic [STATE_W-1:0] q,
  output logic [LED_W-1:0]   leds
);

  always_comb begin
    leds = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (PATTERN == PAT_BAR) begin
        leds[i] = (i <= int'(q));
      end else begin
        leds[i] = (i == int'(q));
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Parametrised LED step sequencer: prescaled tick drives a NUM_STATES-deep
// index through wrap, bounce, single-shot or hold modes, with synchronous load.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int NUM_STATES = 5,
  parameter int DIV        = 25_000_000,
  parameter int LED_W      = 10,
  parameter int PATTERN    = PAT_ONEHOT,
  localparam int STATE_W   = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [STATE_W-1:0] load_val,
  output logic [STATE_W-1:0] q,
  output logic [LED_W-1:0]   leds,
  output logic               step,
  output logic               at_end
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [STATE_W-1:0] LAST    = STATE_W'(NUM_STATES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]   count;
  logic               tick;
  logic               bdir;
  logic               bdir_next;
  logic [STATE_W-1:0] q_next;
  logic [STATE_W-1:0] load_clamped;
  logic               travel_up;
  mode_t              mode_e;

  assign mode_e = mode_t'(mode);
  assign tick   = en && (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Terminal indices are detected by explicit compare so a non-power-of-2
  // depth never reaches an index >= NUM_STATES.
  always_comb begin
    q_next    = q;
    bdir_next = bdir;
    if (NUM_STATES > 1) begin
      case (mode_e)
        MODE_WRAP: begin
          if (dir) begin
            q_next = (q == LAST) ? '0 : q + 1'b1;
          end else begin
            q_next = (q == '0) ? LAST : q - 1'b1;
          end
        end
        MODE_BOUNCE: begin
          if (bdir) begin
            if (q == LAST) begin
              q_next    = q - 1'b1;
              bdir_next = 1'b0;
            end else begin
              q_next = q + 1'b1;
            end
          end else begin
            if (q == '0) begin
              q_next    = q + 1'b1;
              bdir_next = 1'b1;
            end else begin
              q_next = q - 1'b1;
            end
          end
        end
        MODE_ONESHOT: begin
          if (dir) begin
            if (q != LAST) q_next = q + 1'b1;
          end else begin
            if (q != '0) q_next = q - 1'b1;
          end
        end
        default: q_next = q;
      endcase
    end
  end

  assign load_clamped = (load_val > LAST) ? LAST : load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      bdir <= 1'b1;
      step <= 1'b0;
    end else if (load) begin
      q    <= load_clamped;
      step <= 1'b0;
    end else if (tick) begin
      q    <= q_next;
      bdir <= bdir_next;
      step <= (q_next != q);
    end else begin
      step <= 1'b0;
    end
  end

  assign travel_up = (mode_e == MODE_BOUNCE) ? bdir : dir;
  assign at_end    = travel_up ? (q == LAST) : (q == '0);

  led_pattern_decode #(
    .STATE_W (STATE_W),
    .LED_W   (LED_W),
    .PATTERN (PATTERN)
  ) u_decode (
    .q    (q),
    .leds (leds)
  );

endmodule
